key_event_reader: RTL and testbench

Consumer-side partner of the 4-button encoder. It takes the encoder's latched outputs (s1/s0 code plus press flag), synchronises and debounces them, and captures one key event per physical press. It then drives the encoder's clear input to release the latch and queues the event in a small FIFO. Game logic pops events through a valid/ready interface.

---
 rtl/key_event_reader.sv | 139 +++++++++++++
 tb/tb_key_event_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_reader.sv
// Consumer side of the 4-button encoder: synchronises and debounces the latched
// code/press, captures one event per press, releases the encoder latch and queues events.
module key_event_reader #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_AW         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s0,
    input  logic               s1,
    input  logic               press,
    output logic               clear,
    output logic               key_valid,
    output logic [1:0]         key_code,
    output logic [3:0]         key_onehot,
    input  logic               key_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FIFO_AW:0]  DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, CAPTURE, CLEAR_S} state_t;

    state_t             state_q, state_d;
    logic [2:0]         meta_q, sync_q;
    logic [1:0]         cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clear_q, clear_d;
    logic [FIFO_AW-1:0] wr_q, rd_q;
    logic [FIFO_AW:0]   count_q;
    logic               ovf_q;
    logic [1:0]         mem_q [FIFO_DEPTH];

    logic       ps;
    logic [1:0] cs;
    logic       full, pop, push, drop;

    // Two-flop synchronisers; bit order {press, s1, s0}
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 3'b000;
            sync_q <= 3'b000;
        end else begin
            meta_q <= {press, s1, s0};
            sync_q <= meta_q;
        end
    end

    assign ps = sync_q[2];
    assign cs = sync_q[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= 2'b00;
            cnt_q   <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            clear_q <= clear_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ps) begin
                    cand_d  = cs;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!ps) begin
                    state_d = IDLE;
                end else if (cs != cand_q) begin
                    cand_d = cs;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: state_d = CLEAR_S;
            CLEAR_S: if (!ps) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts the capture when the consumer pops in the same cycle
    always_comb begin
        clear_d = (state_d == CLEAR_S);
        push    = (state_q == CAPTURE) && (!full || pop);
        drop    = (state_q == CAPTURE) && full && !pop;
    end

    assign full = (count_q == DEPTH_C);
    assign pop  = key_valid & key_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + FIFO_AW'(1);
            if (pop)  rd_q <= rd_q + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
                2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= cand_q;
    end

    assign key_valid  = (count_q != '0);
    assign key_code   = key_valid ? mem_q[rd_q] : 2'b00;
    assign key_onehot = key_valid ? (4'b0001 << key_code) : 4'b0000;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign clear      = clear_q;

endmodule

// File: tb/tb_key_event_reader.sv
// Directed bench for key_event_reader with DEBOUNCE_CYCLES=4; popped events are
// checked by a monitor against a queue of expected codes filled by the stimulus.
module tb_key_event_reader;

    logic       clk = 1'b0;
    logic       reset, s0, s1, press, key_ready;
    logic       clear, key_valid, overflow;
    logic [1:0] key_code;
    logic [3:0] key_onehot;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;
    logic [1:0] sb [$];

    key_event_reader #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .s0(s0), .s1(s1), .press(press),
        .clear(clear), .key_valid(key_valid), .key_code(key_code),
        .key_onehot(key_onehot), .key_ready(key_ready),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted pop must match the oldest expected event
    always @(negedge clk) begin
        if (!reset && key_valid && key_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got code %0d expected no event", key_code);
            end else begin
                logic [1:0] exp_c;
                exp_c = sb.pop_front();
                if (key_code !== exp_c || key_onehot !== (4'b0001 << exp_c)) begin
                    errors++;
                    $display("FAIL pop_code: got code %0d onehot %b expected code %0d onehot %b",
                             key_code, key_onehot, exp_c, 4'b0001 << exp_c);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        press = 1'b0;
        key_ready = 1'b0;
        tick(3);
        sb.delete();
        reset = 1'b0;
        tick(1);
    endtask

    // Full press: hold long enough to capture, release, let the FSM return to IDLE
    task automatic press_key(input logic [1:0] code);
        {s1, s0} = code;
        press = 1'b1;
        tick(12);
        press = 1'b0;
        tick(5);
    endtask

    task automatic pop_n(input int n);
        key_ready = 1'b1;
        tick(n);
        key_ready = 1'b0;
    endtask

    initial begin
        int clear_hits;
        reset = 1'b1; s0 = 1'b0; s1 = 1'b0; press = 1'b0; key_ready = 1'b0;
        tick(3);
        check("rst_clear", clear, 0);
        check("rst_valid", key_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_code", key_code, 0);
        check("rst_onehot", key_onehot, 0);
        reset = 1'b0;
        tick(2);

        // Single press, code 2: valid and clear appear after edge k+7
        {s1, s0} = 2'd2;
        press = 1'b1;
        sb.push_back(2'd2);
        tick(7);
        check("single_valid_early", key_valid, 0);
        check("single_clear_early", clear, 0);
        tick(1);
        check("single_valid", key_valid, 1);
        check("single_clear", clear, 1);
        check("single_code", key_code, 2);
        check("single_onehot", key_onehot, 4);
        check("single_count", fifo_count, 1);
        press = 1'b0;
        tick(4);
        check("single_release_clear", clear, 0);
        pop_n(1);
        check("single_empty", key_valid, 0);

        // Bounce: press high for only 3 cycles
        {s1, s0} = 2'd1;
        press = 1'b1;
        clear_hits = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) press = 1'b0;
            tick(1);
            if (clear) clear_hits++;
        end
        check("bounce_clear_hits", clear_hits, 0);
        check("bounce_count", fifo_count, 0);

        // Code changes from 1 to 3 mid-debounce
        {s1, s0} = 2'd1;
        press = 1'b1;
        tick(3);
        {s1, s0} = 2'd3;
        sb.push_back(2'd3);
        tick(20);
        check("chg_count", fifo_count, 1);
        check("chg_code", key_code, 3);
        press = 1'b0;
        tick(5);
        pop_n(1);
        check("chg_empty", key_valid, 0);

        // Held key for 100 cycles: one event, clear held until release
        {s1, s0} = 2'd0;
        press = 1'b1;
        sb.push_back(2'd0);
        tick(100);
        check("held_count", fifo_count, 1);
        check("held_clear", clear, 1);
        press = 1'b0;
        tick(5);
        check("held_release_clear", clear, 0);
        check("held_count_after", fifo_count, 1);
        pop_n(1);

        // Overflow: five presses, the fifth is dropped
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back(2'(i));
            press_key(2'(i % 4));
            if (i == 3) check("ovf_before", overflow, 0);
        end
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        pop_n(4);
        check("ovf_drained", key_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Full FIFO with a pop in the CAPTURE cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back(2'(3 - i));
            press_key(2'(3 - i));
        end
        check("fullpop_pre", fifo_count, 4);
        {s1, s0} = 2'd1;
        press = 1'b1;
        sb.push_back(2'd1);
        tick(7);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("fullpop_count", fifo_count, 4);
        check("fullpop_ovf", overflow, 0);
        check("fullpop_clear", clear, 1);
        press = 1'b0;
        tick(5);
        pop_n(4);
        check("fullpop_drained", key_valid, 0);
        check("sb_empty", sb.size(), 0);

        // Reset while the FSM holds clear high
        {s1, s0} = 2'd2;
        press = 1'b1;
        tick(10);
        check("rstclr_pre_clear", clear, 1);
        check("rstclr_pre_count", fifo_count, 1);
        reset = 1'b1;
        press = 1'b0;
        tick(1);
        check("rstclr_clear", clear, 0);
        check("rstclr_count", fifo_count, 0);
        sb.delete();
        tick(2);
        reset = 1'b0;
        tick(3);
        check("rstclr_idle_valid", key_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
